// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the pipeline stage register with skid buffer.
// Provides the control state encoding, the MIPS bubble word and the width
// of the stall statistics counter.
package pipe_pkg;

    typedef enum logic [1:0] {
        STATE_EMPTY = 2'd0,
        STATE_BUSY  = 2'd1,
        STATE_FULL  = 2'd2
    } state_t;

    // sll $0,$0,0 encodes as all zeros, so a zeroed bundle is a NOP.
    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

    localparam int STALL_CNT_WIDTH = 16;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle used on both sides of a pipeline stage.
// The master drives valid and data; the slave drives ready.
interface pipe_stage_skid_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid_sat_counter.sv
// Width-parametrised saturating up-counter with synchronous clear.
// Used for stall statistics; sticks at all-ones instead of wrapping.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int WIDTH = STALL_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (&v) ? v : v + WIDTH'(1);
    endfunction

    // Clear has priority; otherwise count up until all ones.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a two-entry skid buffer, valid/ready
// handshake on both sides, flush (bubble insertion) and synchronous reset.
// in_ready, out_valid and out_data all come straight from flops, so there
// is no combinational path from downstream ready to upstream ready.
// Optional build macro PIPE_STAGE_STATS_EN enables the saturating stall
// counter; without it stall_count is tied to zero.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_VALUE  = DATA_WIDTH'(MIPS_NOP)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    pipe_stage_skid_if.slave           up,
    pipe_stage_skid_if.master          dn,
    output logic [STALL_CNT_WIDTH-1:0] stall_count
);

    state_t                state_p1;
    logic                  in_ready_p1;
    logic                  out_valid_p1;
    logic [DATA_WIDTH-1:0] main_p1;
    logic [DATA_WIDTH-1:0] skid_p1;

    logic in_fire;
    logic out_fire;

    assign in_fire  = up.valid & in_ready_p1;
    assign out_fire = out_valid_p1 & dn.ready;

    assign up.ready = in_ready_p1;
    assign dn.valid = out_valid_p1;
    assign dn.data  = main_p1;

    // Control FSM and storage; reset and flush both empty the stage and
    // load the bubble word, and both override any handshake in flight.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_p1     <= STATE_EMPTY;
            in_ready_p1  <= 1'b1;
            out_valid_p1 <= 1'b0;
            main_p1      <= NOP_VALUE;
            skid_p1      <= NOP_VALUE;
        end else begin
            case (state_p1)
                STATE_EMPTY: begin
                    if (in_fire) begin
                        main_p1      <= up.data;
                        state_p1     <= STATE_BUSY;
                        out_valid_p1 <= 1'b1;
                    end
                end
                STATE_BUSY: begin
                    if (in_fire && out_fire) begin
                        main_p1 <= up.data;
                    end else if (in_fire) begin
                        // Downstream stalled: park the new word in the skid slot.
                        skid_p1     <= up.data;
                        state_p1    <= STATE_FULL;
                        in_ready_p1 <= 1'b0;
                    end else if (out_fire) begin
                        state_p1     <= STATE_EMPTY;
                        out_valid_p1 <= 1'b0;
                    end
                end
                STATE_FULL: begin
                    // in_ready is low here, so only the output side can move.
                    if (out_fire) begin
                        main_p1     <= skid_p1;
                        state_p1    <= STATE_BUSY;
                        in_ready_p1 <= 1'b1;
                    end
                end
                default: begin
                    state_p1     <= STATE_EMPTY;
                    in_ready_p1  <= 1'b1;
                    out_valid_p1 <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    sat_counter #(
        .WIDTH(STALL_CNT_WIDTH)
    ) u_stall_cnt (
        .clk  (clk),
        .clr  (reset),
        .inc  (out_valid_p1 & ~dn.ready),
        .count(stall_count)
    );
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed phases (reset release, streaming,
// skid backpressure, flush in FULL, reset with flush), a random phase and a
// long stall run for the statistics counter. The reference model treats the
// stage as a two-deep FIFO; a scoreboard queue holds accepted words and a
// monitor compares every downstream transfer against it.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [15:0] stall_count;

    pipe_stage_skid_if #(.DATA_WIDTH(32)) up_if ();
    pipe_stage_skid_if #(.DATA_WIDTH(32)) dn_if ();

    pipe_stage_skid #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .up         (up_if),
        .dn         (dn_if),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    int          occ     = 0;
    bit          nop_exp = 1'b1;
    bit          started = 1'b0;
    int          stall_m = 0;
    bit          in_f;
    bit          out_f;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_stall();
`ifdef PIPE_STAGE_STATS_EN
        return stall_m;
`else
        return 0;
`endif
    endfunction

    // Reference model: a FIFO of capacity two, emptied by reset or flush.
    always @(posedge clk) begin
        started = 1'b1;
        if (reset) begin
            occ = 0;
            exp_q.delete();
            nop_exp = 1'b1;
            stall_m = 0;
        end else begin
            if (occ > 0 && !dn_if.ready && stall_m < 65535) stall_m++;
            if (flush) begin
                occ = 0;
                exp_q.delete();
                nop_exp = 1'b1;
            end else begin
                in_f  = up_if.valid && (occ < 2);
                out_f = (occ > 0) && dn_if.ready;
                if (out_f) occ--;
                if (in_f) begin
                    occ++;
                    exp_q.push_back(up_if.data);
                    nop_exp = 1'b0;
                end
            end
        end
    end

    // Monitor: handshake flags, bubble data, stall counter and transfers.
    always @(negedge clk) begin
        if (started) begin
            check("out_valid", 64'(dn_if.valid), 64'(occ > 0));
            check("in_ready", 64'(up_if.ready), 64'(occ < 2));
            if (nop_exp) check("nop_data", 64'(dn_if.data), 64'h0);
            check("stall_count", 64'(stall_count), 64'(exp_stall()));
            if (dn_if.valid && dn_if.ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'(dn_if.data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("out_data", 64'(dn_if.data), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic cyc(input bit v, input logic [31:0] d, input bit r, input bit f, input bit rst);
        up_if.valid = v;
        up_if.data  = d;
        dn_if.ready = r;
        flush       = f;
        reset       = rst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        up_if.valid = 1'b1;
        up_if.data  = 32'hDEADBEEF;
        dn_if.ready = 1'b1;
        flush       = 1'b0;
        reset       = 1'b1;
        #1;

        // Reset held three cycles with input pending, then released.
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Streaming 1..8 with downstream always ready.
        for (int i = 1; i <= 8; i++) cyc(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Backpressure into the skid slot, then release.
        cyc(1'b1, 32'hA, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Fill to FULL, then flush with a word offered.
        cyc(1'b1, 32'h1A, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h1B, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hC, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Reset and flush together while BUSY, then flush while EMPTY.
        cyc(1'b1, 32'h2A, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h2B, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 32'h3A, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0,
                ($urandom % 50) == 0, ($urandom % 200) == 0);
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("drained", 64'(exp_q.size()), 64'h0);

        // Long stall to saturate the statistics counter, then flush.
        cyc(1'b1, 32'h55, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 70000; i++) cyc(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
`ifdef PIPE_STAGE_STATS_EN
        check("stall_sat", 64'(stall_count), 64'hFFFF);
`else
        check("stall_off", 64'(stall_count), 64'h0);
`endif
        #1;
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
`ifdef PIPE_STAGE_STATS_EN
        check("stall_after_flush", 64'(stall_count), 64'hFFFF);
`else
        check("stall_after_flush", 64'(stall_count), 64'h0);
`endif
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
